// File: rtl/btn_input_conditioner_if.sv
// Button conditioner bus.
// Groups the tick/button inputs and the conditioned event outputs of
// btn_input_conditioner so they travel as one bundle.
//   clk_en_pi      : one-cycle debounce tick from clkdiv
//   btn_pi         : raw, asynchronous, bouncing button pins
//   btn_level_po   : debounced button level
//   btn_press_po   : one-clock pulse on debounced 0->1
//   btn_release_po : one-clock pulse on debounced 1->0
//   op_po          : one-hot latched operation select
//   op_valid_po    : high once any press has been latched
// The slave modport is the conditioner; master is whoever drives the pins.
interface btn_input_conditioner_if #(
    parameter int unsigned NUM_BTN = 4
);
    logic               clk_en_pi;
    logic [NUM_BTN-1:0] btn_pi;
    logic [NUM_BTN-1:0] btn_level_po;
    logic [NUM_BTN-1:0] btn_press_po;
    logic [NUM_BTN-1:0] btn_release_po;
    logic [NUM_BTN-1:0] op_po;
    logic               op_valid_po;

    modport master (
        output clk_en_pi,
        output btn_pi,
        input  btn_level_po,
        input  btn_press_po,
        input  btn_release_po,
        input  op_po,
        input  op_valid_po
    );

    modport slave (
        input  clk_en_pi,
        input  btn_pi,
        output btn_level_po,
        output btn_press_po,
        output btn_release_po,
        output op_po,
        output op_valid_po
    );
endinterface

// File: rtl/btn_input_conditioner.sv
// Push-button front end: two-flop synchronizer, per-bit tick-based debounce,
// press/release edge pulses and a one-hot operation-select latch.
//   clk_pi   : system clock, rising edge
//   rst_n_pi : asynchronous active-low reset
//   bus      : btn_input_conditioner_if slave (tick, raw pins, conditioned outputs)
// Each bit is a LOW/HIGH state plus a counter of consecutive ticks during which
// the synchronized input disagreed with the debounced level.
module btn_input_conditioner #(
    parameter int unsigned NUM_BTN  = 4,
    parameter int unsigned DB_TICKS = 4,
    parameter int unsigned CNT_W    = 5
) (
    input logic                    clk_pi,
    input logic                    rst_n_pi,
    btn_input_conditioner_if.slave bus
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_TICKS - 1);

    typedef enum logic {StLow = 1'b0, StHigh = 1'b1} db_state_e;

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    db_state_e          state_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
    logic [NUM_BTN-1:0] press_q;
    logic [NUM_BTN-1:0] release_q;
    logic [NUM_BTN-1:0] op_q;
    logic               op_valid_q;
    logic [NUM_BTN-1:0] op_d;
    logic [NUM_BTN-1:0] level;

    // Lowest-index set bit of the registered press vector wins.
    always_comb begin
        logic found;
        found = 1'b0;
        op_d  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            op_d[i] = press_q[i] & ~found;
            found   = found | press_q[i];
        end
    end

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
            op_q       <= '0;
            op_valid_q <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= StLow;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= bus.btn_pi;
            sync2_q   <= sync1_q;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2_q[i] == (state_q[i] == StHigh)) begin
                    // Agreement on any clock restarts the count: rejects glitches.
                    cnt_q[i] <= '0;
                end else if (bus.clk_en_pi) begin
                    if (cnt_q[i] == CntLast) begin
                        cnt_q[i] <= '0;
                        case (state_q[i])
                            StLow: begin
                                state_q[i] <= StHigh;
                                press_q[i] <= 1'b1;
                            end
                            default: begin
                                state_q[i]   <= StLow;
                                release_q[i] <= 1'b1;
                            end
                        endcase
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
            if (press_q != '0) begin
                op_q       <= op_d;
                op_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        level = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            level[i] = (state_q[i] == StHigh);
        end
    end

    assign bus.btn_level_po   = level;
    assign bus.btn_press_po   = press_q;
    assign bus.btn_release_po = release_q;
    assign bus.op_po          = op_q;
    assign bus.op_valid_po    = op_valid_q;

endmodule

// File: doc/btn_input_conditioner.md
Name: btn_input_conditioner

Overview:
Input-side front end for the lab board. The display path converts internal values into pin activity; this block converts raw pin activity from the push-buttons into clean internal events. It synchronizes, debounces and edge-detects the BTN inputs using the shared clkdiv enable tick. It also latches a one-hot operation select that is held stable for the calculator op input.

Parameters:
NUM_BTN, 4, number of button inputs conditioned.
DB_TICKS, 4, consecutive clk_en_pi ticks a synchronized input must differ from its debounced level before the level changes (legal range 2..31).
CNT_W, 5, width of each per-button debounce counter; must satisfy 2^CNT_W > DB_TICKS.

Ports:
clk_pi  input  1  system clock; all logic on rising edge.
rst_n_pi  input  1  asynchronous active-low reset.
clk_en_pi  input  1  one-cycle debounce tick from clkdiv.
btn_pi  input  NUM_BTN  raw, asynchronous, bouncing button pins.
btn_level_po  output  NUM_BTN  debounced button level.
btn_press_po  output  NUM_BTN  one-clock pulse on debounced 0->1.
btn_release_po  output  NUM_BTN  one-clock pulse on debounced 1->0.
op_po  output  NUM_BTN  one-hot latched operation select.
op_valid_po  output  1  high once any press has been latched.

Behaviour:
- Reset (asynchronous, rst_n_pi=0):
  - All outputs are 0.
  - Synchronizer flops, debounced levels and counters are 0.
  - Reset mid-debounce discards the partial count.
  - After rst_n_pi rises, a button already held down must still pass full debounce before its level changes.
- Synchronizer: two flops per bit. sync[i] lags btn_pi[i] by 2 clocks.
- Per-bit debounce, each bit independent. It is a 2-state FSM, LOW/HIGH, equal to btn_level_po[i], plus a counter cnt[i]:
  - sync==level on any clock: cnt clears to 0, whether or not clk_en_pi is high. This rejects glitches.
  - sync!=level, clk_en_pi=1, cnt<DB_TICKS-1: cnt increments.
  - sync!=level, clk_en_pi=1, cnt==DB_TICKS-1: at the same edge the level toggles, cnt clears, and the matching pulse is set.
    - LOW->HIGH sets btn_press_po[i].
    - HIGH->LOW sets btn_release_po[i].
  - sync!=level, clk_en_pi=0: cnt holds.
- Pulses:
  - btn_press_po and btn_release_po are registered and high for exactly one clk_pi cycle.
  - Each pulse is coincident with the first cycle of the new level.
  - A press pulse and a release pulse never coexist on the same bit.
- Latency: from a clean btn_pi edge to the level/pulse output is 2 clocks plus the clocks needed to accumulate DB_TICKS enable ticks, plus 1 register stage.
- Op latch:
  - On any clock where btn_press_po!=0 (the registered pulse vector), op_po takes the one-hot of the lowest-index set bit at the next edge, and op_valid_po is set to 1.
  - Simultaneous presses resolve by this fixed priority, bit 0 highest.
  - op_po holds until the next press; releases do not change it.
  - op_po is always one-hot, or all-zero only while op_valid_po=0.
- Counter width: cnt never exceeds DB_TICKS-1, so no wrap is possible.
- clk_en_pi held constantly high is legal. Debounce then counts clocks instead of ticks.

Test Plan:
- Clean press, with DB_TICKS=4 and clk_en_pi every 4th cycle: btn_pi[2] 0->1 and held -> btn_level_po[2] rises on the 4th tick after the sync delay, btn_press_po=0100 for one cycle, then op_po=0100 and op_valid_po=1 on the next cycle.
- Bounce rejection: btn_pi[0] toggles high for 3 ticks, low for 1 clock, then high steadily -> no pulse during the bounce; the counter restarts, and press fires only 4 full ticks after the last bounce.
- Release: hold btn_pi[1] until its level is 1, then drop it -> btn_release_po=0010 for one cycle after 4 ticks; op_po is unchanged.
- Simultaneous press: btn_pi 0000->1010 on the same clock -> btn_press_po=1010 in one cycle, op_po=0010 (bit 1 wins).
- Reset mid-operation: assert rst_n_pi during tick 2 of debouncing btn_pi[3] while btn_pi[3] stays high -> all outputs go to 0 immediately; after release, a full 4 ticks plus sync delay is needed before btn_press_po[3] fires.
- Glitch without tick: btn_pi[0] pulses high for 2 clocks between enable ticks -> cnt[0] stays 0 and no output changes.
